// File: rtl/fifo3_byte_repack.sv
// Repacks 3-bit FIFO symbols (LSB-first) into bytes on a valid/ready port.
// Optional macro FIFO3_REPACK_PARITY_EN adds a registered byte_parity output.
module fifo3_byte_repack #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [2:0]       fifo_data,
  output logic             fifo_r_en,
  input  logic             flush,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic [2:0]       sym_phase,
  output logic             group_done,
  output logic [CNT_W-1:0] byte_count
`ifdef FIFO3_REPACK_PARITY_EN
  ,
  output logic             byte_parity
`endif
);

  logic [10:0]      acc_q, acc_d;
  logic [3:0]       acc_cnt_q, acc_cnt_d;
  logic             pend_q, pend_d;
  logic [7:0]       byte_data_q, byte_data_d;
  logic             byte_valid_q, byte_valid_d;
  logic [2:0]       sym_phase_q, sym_phase_d;
  logic             group_done_q, group_done_d;
  logic [CNT_W-1:0] byte_count_q, byte_count_d;
`ifdef FIFO3_REPACK_PARITY_EN
  logic             byte_parity_q, byte_parity_d;
`endif

  logic [4:0]  fill;
  logic        absorb;
  logic        drain;
  logic        xfer;
  logic [10:0] acc_base;
  logic [3:0]  cnt_base;

  always_comb begin
    // Count bits already held plus those still in flight so acc never overflows.
    fill      = {1'b0, acc_cnt_q} + (pend_q ? 5'd3 : 5'd0);
    fifo_r_en = ~fifo_empty & ~flush & (fill <= 5'd7);
    pend_d    = fifo_r_en;

    absorb = pend_q & ~flush;
    xfer   = byte_valid_q & byte_ready;
    drain  = ~flush & (acc_cnt_q >= 4'd8) & (~byte_valid_q | byte_ready);

    // Drain shifts first; an absorb in the same cycle lands on the shifted image.
    acc_base = drain ? {8'd0, acc_q[10:8]} : acc_q;
    cnt_base = drain ? (acc_cnt_q - 4'd8) : acc_cnt_q;

    acc_d        = acc_base;
    acc_cnt_d    = cnt_base;
    sym_phase_d  = sym_phase_q;
    group_done_d = 1'b0;

    if (flush) begin
      acc_d       = '0;
      acc_cnt_d   = '0;
      sym_phase_d = '0;
    end else if (absorb) begin
      acc_d        = acc_base | ({8'd0, fifo_data} << cnt_base);
      acc_cnt_d    = cnt_base + 4'd3;
      sym_phase_d  = sym_phase_q + 3'd1;
      group_done_d = (sym_phase_q == 3'd7);
    end

    byte_data_d  = byte_data_q;
    byte_valid_d = byte_valid_q & ~xfer;
`ifdef FIFO3_REPACK_PARITY_EN
    byte_parity_d = byte_parity_q;
`endif
    if (drain) begin
      byte_data_d  = acc_q[7:0];
      byte_valid_d = 1'b1;
`ifdef FIFO3_REPACK_PARITY_EN
      byte_parity_d = ^acc_q[7:0];
`endif
    end

    byte_count_d = byte_count_q + {{(CNT_W-1){1'b0}}, xfer};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      pend_q       <= 1'b0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      sym_phase_q  <= '0;
      group_done_q <= 1'b0;
      byte_count_q <= '0;
`ifdef FIFO3_REPACK_PARITY_EN
      byte_parity_q <= 1'b0;
`endif
    end else begin
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      pend_q       <= pend_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      sym_phase_q  <= sym_phase_d;
      group_done_q <= group_done_d;
      byte_count_q <= byte_count_d;
`ifdef FIFO3_REPACK_PARITY_EN
      byte_parity_q <= byte_parity_d;
`endif
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign sym_phase  = sym_phase_q;
  assign group_done = group_done_q;
  assign byte_count = byte_count_q;
`ifdef FIFO3_REPACK_PARITY_EN
  assign byte_parity = byte_parity_q;
`endif

endmodule
